pitch_frame_scheduler: RTL and testbench



---
 rtl/pitch_sched_pkg.sv | 16 +
 rtl/pitch_frame_scheduler_median3.sv | 47 ++++
 rtl/pitch_frame_scheduler.sv | 171 +++++++++++++++++
 tb/tb_pitch_frame_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_sched_pkg.sv
// Shared types for the pitch frame scheduler: FSM state encoding and the
// default taumin width used by the scheduler and its median filter.
package pitch_sched_pkg;

   localparam int TAU_WIDTH_DEFAULT = 11;

   typedef enum logic [2:0] {
      FILL,
      IDLE,
      START,
      BUSY,
      PUBLISH,
      PUBLISH_WAIT
   } sched_state_e;

endpackage

// File: rtl/pitch_frame_scheduler_median3.sv
// Three-tap median over the most recent voiced taumin values; passes the
// newest value straight through until three values have been collected.
module median3
   import pitch_sched_pkg::*;
#(
   parameter int TAU_WIDTH = TAU_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [TAU_WIDTH-1:0] din,
   output logic [TAU_WIDTH-1:0] med
);

   logic [TAU_WIDTH-1:0] h0;
   logic [TAU_WIDTH-1:0] h1;
   logic [TAU_WIDTH-1:0] h2;
   logic [1:0]           depth;
   logic [TAU_WIDTH-1:0] lo_01;
   logic [TAU_WIDTH-1:0] hi_01;
   logic [TAU_WIDTH-1:0] lo_hi2;
   logic [TAU_WIDTH-1:0] mid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h0    <= '0;
         h1    <= '0;
         h2    <= '0;
         depth <= 2'd0;
      end else if (push) begin
         h2 <= h1;
         h1 <= h0;
         h0 <= din;
         if (depth != 2'd3) depth <= depth + 2'd1;
      end
   end

   // median = max(min(a,b), min(max(a,b), c))
   always_comb begin
      lo_01  = (h0 < h1) ? h0 : h1;
      hi_01  = (h0 < h1) ? h1 : h0;
      lo_hi2 = (hi_01 < h2) ? hi_01 : h2;
      mid    = (lo_01 > lo_hi2) ? lo_01 : lo_hi2;
      med    = (depth == 2'd3) ? mid : h0;
   end

endmodule

// File: rtl/pitch_frame_scheduler.sv
// Schedules YIN detector runs on the sample stream: window fill, hop-based
// start pulses, watchdog, range-checked publish. PITCH_MEDIAN_EN adds a median stage.
module pitch_frame_scheduler
   import pitch_sched_pkg::*;
#(
   parameter int WINDOW_SIZE    = 2048,
   parameter int HOP_SIZE       = 512,
   parameter int TAU_LO         = 20,
   parameter int TAU_HI         = 2000,
   parameter int TIMEOUT_CYCLES = 4000000,
   parameter int TAU_WIDTH      = TAU_WIDTH_DEFAULT
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 enable_in,
   input  logic                 sample_valid_in,
   output logic                 start_out,
   input  logic                 done_in,
   input  logic [TAU_WIDTH-1:0] taumin_in,
   output logic [TAU_WIDTH-1:0] taumin_out,
   output logic                 taumin_valid_out,
   output logic                 voiced_out,
   output logic                 timeout_out,
   output logic [15:0]          overrun_count_out
);

   localparam int FILL_W = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
   localparam int HOP_W  = (HOP_SIZE > 1) ? $clog2(HOP_SIZE) : 1;
   localparam int BUSY_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(WINDOW_SIZE - 1);
   localparam logic [HOP_W-1:0]     HOP_LAST  = HOP_W'(HOP_SIZE - 1);
   localparam logic [BUSY_W-1:0]    BUSY_LAST = BUSY_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TAU_WIDTH-1:0] TAU_LO_V  = TAU_WIDTH'(TAU_LO);
   localparam logic [TAU_WIDTH-1:0] TAU_HI_V  = TAU_WIDTH'(TAU_HI);

   sched_state_e      state;
   sched_state_e      state_nxt;
   logic [FILL_W-1:0] fill_cnt;
   logic [HOP_W-1:0]  hop_cnt;
   logic [BUSY_W-1:0] busy_cnt;
   logic              hop_wrap;
   logic              tau_voiced;
   logic              accept_done;
   logic              busy_expire;

   assign hop_wrap    = sample_valid_in && (hop_cnt == HOP_LAST);
   assign tau_voiced  = (taumin_in >= TAU_LO_V) && (taumin_in <= TAU_HI_V);
   assign accept_done = (state == BUSY) && done_in;
   // done_in wins over the watchdog when both land in the same cycle
   assign busy_expire = (state == BUSY) && !done_in && (busy_cnt == BUSY_LAST);

   always_comb begin
      state_nxt        = state;
      start_out        = 1'b0;
      taumin_valid_out = 1'b0;
      case (state)
         FILL: begin
            if (sample_valid_in && (fill_cnt == FILL_LAST)) state_nxt = IDLE;
         end
         IDLE: begin
            if (enable_in && hop_wrap) state_nxt = START;
         end
         START: begin
            start_out = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: begin
            if (done_in) begin
`ifdef PITCH_MEDIAN_EN
               state_nxt = PUBLISH_WAIT;
`else
               state_nxt = PUBLISH;
`endif
            end else if (busy_cnt == BUSY_LAST) begin
               state_nxt = IDLE;
            end
         end
         PUBLISH_WAIT: begin
            state_nxt = PUBLISH;
         end
         PUBLISH: begin
            taumin_valid_out = 1'b1;
            state_nxt        = IDLE;
         end
         default: begin
            state_nxt = FILL;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state             <= FILL;
         fill_cnt          <= '0;
         hop_cnt           <= '0;
         busy_cnt          <= '0;
         timeout_out       <= 1'b0;
         overrun_count_out <= 16'd0;
      end else begin
         state       <= state_nxt;
         timeout_out <= busy_expire;

         case (state)
            FILL: begin
               if (sample_valid_in && (fill_cnt != FILL_LAST)) fill_cnt <= fill_cnt + 1'b1;
               hop_cnt <= '0;
            end
            IDLE: begin
               if (!enable_in)          hop_cnt <= '0;
               else if (hop_wrap)       hop_cnt <= '0;
               else if (sample_valid_in) hop_cnt <= hop_cnt + 1'b1;
            end
            default: begin
               // a hop boundary while a frame is still in flight drops that frame
               if (hop_wrap) begin
                  hop_cnt <= '0;
                  if (overrun_count_out != 16'hFFFF) overrun_count_out <= overrun_count_out + 16'd1;
               end else if (sample_valid_in) begin
                  hop_cnt <= hop_cnt + 1'b1;
               end
            end
         endcase

         if (state == START)     busy_cnt <= '0;
         else if (state == BUSY) busy_cnt <= busy_cnt + 1'b1;
      end
   end

`ifdef PITCH_MEDIAN_EN
   logic                 pend_voiced;
   logic                 push_voiced;
   logic [TAU_WIDTH-1:0] med_tau;

   assign push_voiced = accept_done && tau_voiced;

   median3 #(.TAU_WIDTH(TAU_WIDTH)) u_median3 (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .push  (push_voiced),
      .din   (taumin_in),
      .med   (med_tau)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         pend_voiced <= 1'b0;
         voiced_out  <= 1'b0;
         taumin_out  <= '0;
      end else begin
         if (accept_done) pend_voiced <= tau_voiced;
         if (state == PUBLISH_WAIT) begin
            voiced_out <= pend_voiced;
            if (pend_voiced) taumin_out <= med_tau;
         end
      end
   end
`else
   // result registers settle on the done edge so they are stable during PUBLISH
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         voiced_out <= 1'b0;
         taumin_out <= '0;
      end else if (accept_done) begin
         voiced_out <= tau_voiced;
         if (tau_voiced) taumin_out <= taumin_in;
      end
   end
`endif

endmodule

// File: tb/tb_pitch_frame_scheduler.sv
// Directed bench for pitch_frame_scheduler; expected events (start, publish,
// timeout) are queued with the cycle they must appear in and checked by a monitor.
module tb_pitch_frame_scheduler;

   localparam int W = 34;
   localparam logic [1:0] K_START = 2'd1;
   localparam logic [1:0] K_PUB   = 2'd2;
   localparam logic [1:0] K_TO    = 2'd3;
`ifdef PITCH_MEDIAN_EN
   localparam int PUB_LAT = 2;
`else
   localparam int PUB_LAT = 1;
`endif

   logic        clk          = 1'b0;
   logic        rst_n        = 1'b0;
   logic        enable       = 1'b0;
   logic        sample_valid = 1'b0;
   logic        done         = 1'b0;
   logic [10:0] tau_drv      = 11'd0;
   logic        start_out;
   logic [10:0] taumin_out;
   logic        taumin_valid_out;
   logic        voiced_out;
   logic        timeout_out;
   logic [15:0] overrun_count_out;

   int          cyc       = 0;
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   int          last_smp  = 0;
   logic [10:0] model_tau = 11'd0;
   logic [W-1:0] exp_q[$];
`ifdef PITCH_MEDIAN_EN
   logic [10:0] hist[3];
   int          hcnt = 0;
`endif

   pitch_frame_scheduler #(
      .WINDOW_SIZE    (8),
      .HOP_SIZE       (4),
      .TAU_LO         (20),
      .TAU_HI         (2000),
      .TIMEOUT_CYCLES (50),
      .TAU_WIDTH      (11)
   ) dut (
      .clk_in            (clk),
      .rst_n_in          (rst_n),
      .enable_in         (enable),
      .sample_valid_in   (sample_valid),
      .start_out         (start_out),
      .done_in           (done),
      .taumin_in         (tau_drv),
      .taumin_out        (taumin_out),
      .taumin_valid_out  (taumin_valid_out),
      .voiced_out        (voiced_out),
      .timeout_out       (timeout_out),
      .overrun_count_out (overrun_count_out)
   );

   // clock/reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // scoreboard monitor
   task automatic observe(input string name, input logic [W-1:0] obs);
      logic [W-1:0] req;
      if (exp_q.size() == 0) begin
         total_cnt++;
         $display("FAIL %s: unexpected event %0h, required none (cycle %0d)", name, obs, cyc);
      end else begin
         req = exp_q.pop_front();
         check(name, obs, req);
      end
   endtask

   always @(negedge clk) begin
      if (start_out)        observe("start_event", {K_START, 1'b0, 11'd0, cyc[19:0]});
      if (taumin_valid_out) observe("publish_event", {K_PUB, voiced_out, taumin_out, cyc[19:0]});
      if (timeout_out)      observe("timeout_event", {K_TO, 1'b0, 11'd0, cyc[19:0]});
   end

   function automatic logic [10:0] med_of(input logic [10:0] a, input logic [10:0] b,
                                          input logic [10:0] c);
      logic [10:0] t;
      if (a > b) begin t = a; a = b; b = t; end
      if (b > c) begin t = b; b = c; c = t; end
      if (a > b) begin t = a; a = b; b = t; end
      return b;
   endfunction

   task automatic expect_publish(input logic [10:0] tau);
      logic v;
      v = (tau >= 11'd20) && (tau <= 11'd2000);
      if (v) begin
`ifdef PITCH_MEDIAN_EN
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = tau;
         if (hcnt < 3) hcnt++;
         model_tau = (hcnt == 3) ? med_of(hist[0], hist[1], hist[2]) : tau;
`else
         model_tau = tau;
`endif
      end
      exp_q.push_back({K_PUB, v, model_tau, 20'(cyc + PUB_LAT)});
   endtask

   // driver tasks: each call starts and ends 1 time unit after a rising edge
   task automatic step();
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      done         = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic smp(input bit exp_start);
      last_smp = cyc;
      if (exp_start) exp_q.push_back({K_START, 1'b0, 11'd0, 20'(cyc + 1)});
      sample_valid = 1'b1;
      step();
   endtask

   task automatic period(input bit exp_start);
      smp(exp_start);
      idle(4);
   endtask

   task automatic dn(input logic [10:0] tau);
      expect_publish(tau);
      done    = 1'b1;
      tau_drv = tau;
      step();
   endtask

   // hop-completing sample, then done_in three cycles after start_out
   task automatic frame_done(input logic [10:0] tau);
      smp(1'b1);
      idle(3);
      dn(tau);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(3);
      check("rst_start", start_out, 0);
      check("rst_valid", taumin_valid_out, 0);
      check("rst_voiced", voiced_out, 0);
      check("rst_taumin", taumin_out, 0);
      check("rst_timeout", timeout_out, 0);
      check("rst_overrun", overrun_count_out, 0);
      model_tau = 11'd0;
`ifdef PITCH_MEDIAN_EN
      hcnt = 0;
`endif
      rst_n = 1'b1;
   endtask

   initial begin
      int t;
      #1;
      do_reset();
      enable = 1'b1;

      // window fill, then a start every 4 samples
      repeat (8) period(1'b0);
      repeat (3) period(1'b0);
      frame_done(11'd100);
      repeat (3) period(1'b0);
      frame_done(11'd5);

      // watchdog expiry with the sample stream paused
      repeat (3) period(1'b0);
      smp(1'b1);
      t = last_smp;
      exp_q.push_back({K_TO, 1'b0, 11'd0, 20'(t + 52)});
      idle(60);

      // next hop starts normally; done lands on the last BUSY cycle
      repeat (3) period(1'b0);
      smp(1'b1);
      idle(50);
      dn(11'd300);

      // overrun: four samples pass while busy
      repeat (3) period(1'b0);
      smp(1'b1);
      idle(4);
      repeat (4) period(1'b0);
      smp(1'b0);
      idle(3);
      dn(11'd50);
      check("overrun_after_drop", overrun_count_out, 1);
      repeat (2) period(1'b0);
      frame_done(11'd1500);

      // reset in the middle of BUSY
      repeat (3) period(1'b0);
      smp(1'b1);
      idle(10);
      do_reset();
      repeat (8) period(1'b0);
      repeat (3) period(1'b0);
      frame_done(11'd800);
      check("overrun_after_reset", overrun_count_out, 0);

      // enable low for 20 samples
      enable = 1'b0;
      repeat (20) period(1'b0);
      enable = 1'b1;
      repeat (3) period(1'b0);
      frame_done(11'd40);

      // median sequence from a clean history
      do_reset();
      repeat (8) period(1'b0);
      repeat (3) period(1'b0);
      frame_done(11'd100);
      repeat (3) period(1'b0);
      frame_done(11'd300);
      repeat (3) period(1'b0);
      frame_done(11'd200);
      repeat (3) period(1'b0);
      frame_done(11'd100);

      idle(10);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
